// File: rtl/cache_axi_resp_pkg.sv
// Shared types and widths for the cache-bus memory responder.
// Both channel FSMs and the latency counters are sized from here.
package cache_axi_resp_pkg;

    localparam int BEAT_W = 4;
    localparam int LAT_W  = 4;

    typedef enum logic [2:0] {
        R_IDLE,
        R_WAIT,
        R_RESP,
        R_NEXT,
        R_DRAIN
    } rd_state_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_WAIT,
        W_RESP,
        W_NEXT,
        W_DRAIN
    } wr_state_e;

    // Wait-state count loaded at sample; the RESP state supplies the final latency cycle.
    function automatic logic [LAT_W-1:0] wait_init(input int unsigned latency);
        return (latency > 1) ? LAT_W'(latency - 2) : '0;
    endfunction

endpackage

// File: rtl/cache_axi_responder_if.sv
// Simplified cache bus between the cache/AXI block (master) and the memory responder (slave).
interface cache_axi_responder_if;

    logic        axi_ce_i;
    logic [3:0]  axi_sel_i;
    logic        axi_ren_i;
    logic        axi_rready_i;
    logic [31:0] axi_raddr_i;
    logic [3:0]  axi_rlen_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        axi_wen_i;
    logic        axi_wvalid_i;
    logic [31:0] axi_waddr_i;
    logic [31:0] axi_wdata_i;
    logic        axi_wlast_i;
    logic [3:0]  axi_wlen_i;
    logic        wdata_resp_o;
    logic        err_o;

    modport master (
        output axi_ce_i, axi_sel_i,
        output axi_ren_i, axi_rready_i, axi_raddr_i, axi_rlen_i,
        output axi_wen_i, axi_wvalid_i, axi_waddr_i, axi_wdata_i, axi_wlast_i, axi_wlen_i,
        input  rdata_o, rdata_valid_o, wdata_resp_o, err_o
    );

    modport slave (
        input  axi_ce_i, axi_sel_i,
        input  axi_ren_i, axi_rready_i, axi_raddr_i, axi_rlen_i,
        input  axi_wen_i, axi_wvalid_i, axi_waddr_i, axi_wdata_i, axi_wlast_i, axi_wlen_i,
        output rdata_o, rdata_valid_o, wdata_resp_o, err_o
    );

endinterface

// File: rtl/cache_axi_resp_ram.sv
// Simple dual-port word RAM: one registered read port, one byte-enabled write port.
// A read and write to the same word on the same edge returns the old contents.
module cache_axi_resp_ram #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [31:0]           rdata_o,
    input  logic                  we_i,
    input  logic [3:0]            wsel_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]           wdata_i
);

    logic [31:0] mem_q [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM and keeps its contents across rst.
    // NOTE: non-blocking assignments make the read see the pre-write word on a same-edge collision.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wsel_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_axi_responder.sv
// Memory-side responder for the cache bus: independent read and write FSMs serving
// single-word or 8-beat bursts from a shared dual-port RAM with configurable latency.
module cache_axi_responder
    import cache_axi_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_axi_responder_if.slave  bus
);

    localparam logic [LAT_W-1:0] RD_WAIT_INIT = wait_init(RD_LATENCY);
    localparam logic [LAT_W-1:0] WR_WAIT_INIT = wait_init(WR_LATENCY);

    rd_state_e             rd_state_q, rd_state_d;
    logic [BEAT_W-1:0]     rbeat_q, rbeat_d, rlen_q, rlen_d;
    logic [LAT_W-1:0]      rcnt_q, rcnt_d;
    logic                  rd_req, rd_sample, rd_err, rd_valid;

    wr_state_e             wr_state_q, wr_state_d;
    logic [BEAT_W-1:0]     wbeat_q, wbeat_d, wlen_q, wlen_d, wbeat_now, wlen_now;
    logic [LAT_W-1:0]      wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wsel_q, wsel_d;
    logic                  wr_req, wr_sample, wr_err, wr_commit;

    logic                  err_q;
    logic [31:0]           ram_rdata;
    logic                  unused_addr_hi;

    assign rd_req = bus.axi_ren_i & bus.axi_rready_i & bus.axi_ce_i;
    assign wr_req = bus.axi_wen_i & bus.axi_wvalid_i & bus.axi_ce_i;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        rd_state_d = rd_state_q;
        rbeat_d    = rbeat_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        rd_sample  = 1'b0;
        rd_err     = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (rd_req) begin
                    rd_sample = 1'b1;
                    rlen_d    = bus.axi_rlen_i;
                    rbeat_d   = '0;
                end
            end
            R_WAIT: begin
                if (rcnt_q == '0) rd_state_d = R_RESP;
                else              rcnt_d     = rcnt_q - 1'b1;
            end
            R_RESP: begin
                if (rbeat_q == rlen_q) begin
                    rd_state_d = R_DRAIN;
                end else begin
                    rbeat_d    = rbeat_q + 1'b1;
                    rd_state_d = R_NEXT;
                end
            end
            R_NEXT: begin
                if (!bus.axi_ren_i) begin
                    rd_state_d = R_IDLE;
                    rd_err     = 1'b1;
                end else if (rd_req) begin
                    rd_sample = 1'b1;
                end
            end
            R_DRAIN: begin
                if (!bus.axi_ren_i) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
        if (rd_sample) begin
            rcnt_d     = RD_WAIT_INIT;
            rd_state_d = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
            if (bus.axi_raddr_i[1:0] != 2'b00) rd_err = 1'b1;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wbeat_d    = wbeat_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wsel_d     = wsel_q;
        wbeat_now  = wbeat_q;
        wlen_now   = wlen_q;
        wr_sample  = 1'b0;
        wr_err     = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (wr_req) begin
                    wr_sample = 1'b1;
                    wlen_d    = bus.axi_wlen_i;
                    wbeat_d   = '0;
                    wbeat_now = '0;
                    wlen_now  = bus.axi_wlen_i;
                end
            end
            W_WAIT: begin
                if (wcnt_q == '0) wr_state_d = W_RESP;
                else              wcnt_d     = wcnt_q - 1'b1;
            end
            W_RESP: begin
                if (wbeat_q == wlen_q) begin
                    wr_state_d = W_DRAIN;
                end else begin
                    wbeat_d    = wbeat_q + 1'b1;
                    wr_state_d = W_NEXT;
                end
            end
            W_NEXT: begin
                if (!bus.axi_wen_i) begin
                    wr_state_d = W_IDLE;
                    wr_err     = 1'b1;
                end else if (wr_req) begin
                    wr_sample = 1'b1;
                end
            end
            W_DRAIN: begin
                if (!bus.axi_wen_i) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (wr_sample) begin
            waddr_d    = bus.axi_waddr_i[ADDR_WIDTH+1:2];
            wdata_d    = bus.axi_wdata_i;
            wsel_d     = bus.axi_sel_i;
            wcnt_d     = WR_WAIT_INIT;
            wr_state_d = (WR_LATENCY == 1) ? W_RESP : W_WAIT;
            // A mismatched wlast is flagged but the beat is still written.
            if (bus.axi_wlast_i != (wbeat_now == wlen_now)) wr_err = 1'b1;
            if (bus.axi_waddr_i[1:0] != 2'b00)              wr_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rbeat_q    <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            wr_state_q <= W_IDLE;
            wbeat_q    <= '0;
            wlen_q     <= '0;
            wcnt_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wsel_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rbeat_q    <= rbeat_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
            wr_state_q <= wr_state_d;
            wbeat_q    <= wbeat_d;
            wlen_q     <= wlen_d;
            wcnt_q     <= wcnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wsel_q     <= wsel_d;
            err_q      <= err_q | rd_err | wr_err;
        end
    end

    // A reset landing on the commit cycle drops the beat rather than writing it.
    assign wr_commit = (wr_state_q == W_RESP) & ~rst;
    assign rd_valid  = (rd_state_q == R_RESP);

    cache_axi_resp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .re_i    (rd_sample),
        .raddr_i (bus.axi_raddr_i[ADDR_WIDTH+1:2]),
        .rdata_o (ram_rdata),
        .we_i    (wr_commit),
        .wsel_i  (wsel_q),
        .waddr_i (waddr_q),
        .wdata_i (wdata_q)
    );

    assign bus.rdata_valid_o = rd_valid;
    assign bus.rdata_o       = rd_valid ? ram_rdata : '0;
    assign bus.wdata_resp_o  = wr_commit;
    assign bus.err_o         = err_q;

    assign unused_addr_hi = ^{bus.axi_raddr_i[31:ADDR_WIDTH+2], bus.axi_waddr_i[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_cache_axi_responder.sv
// Randomized scoreboard bench for cache_axi_responder against a word-array reference model.
module tb_cache_axi_responder;

    localparam int AW     = 14;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_axi_responder_if bus ();

    cache_axi_responder #(
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    rd_exp_t     rd_q [$];
    int          wr_q [$];
    logic [31:0] model [int unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory has 2^AW words; higher byte-address bits alias.
    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % (2 ** AW);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned w = widx(a);
        return model.exists(w) ? model[w] : 32'h0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        int unsigned w = widx(a);
        logic [31:0] old = model.exists(w) ? model[w] : 32'h0;
        logic [31:0] mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        model[w] = (old & ~mask) | (d & mask);
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        rd_exp_t e;
        int      wc;
        if (bus.rdata_valid_o === 1'b1) begin
            check("rd_pulse_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                e = rd_q.pop_front();
                check("rd_data", bus.rdata_o, e.data);
                check("rd_cycle", cyc, e.cyc);
            end
        end
        if (bus.wdata_resp_o === 1'b1) begin
            check("wr_pulse_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                wc = wr_q.pop_front();
                check("wr_cycle", cyc, wc);
            end
        end
    end

    task automatic idle_inputs();
        bus.axi_ce_i     = 1'b1;
        bus.axi_sel_i    = 4'h0;
        bus.axi_ren_i    = 1'b0;
        bus.axi_rready_i = 1'b0;
        bus.axi_raddr_i  = 32'h0;
        bus.axi_rlen_i   = 4'h0;
        bus.axi_wen_i    = 1'b0;
        bus.axi_wvalid_i = 1'b0;
        bus.axi_waddr_i  = 32'h0;
        bus.axi_wdata_i  = 32'h0;
        bus.axi_wlast_i  = 1'b0;
        bus.axi_wlen_i   = 4'h0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic read_beat(input logic [31:0] a, input int len);
        rd_exp_t e;
        bit      got = 1'b0;
        @(posedge clk); #1;
        bus.axi_ce_i     = 1'b1;
        bus.axi_ren_i    = 1'b1;
        bus.axi_rready_i = 1'b1;
        bus.axi_raddr_i  = a;
        bus.axi_rlen_i   = 4'(len);
        e.data = model_read(a);
        e.cyc  = cyc + RD_LAT;
        rd_q.push_back(e);
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = bus.rdata_valid_o;
        end
        check("rd_pulse_seen", 32'(got), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] base, input int len, input int gap_max,
                           input bit use_ce, input int drain_hold);
        for (int b = 0; b <= len; b++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(posedge clk); #1;
                bus.axi_ren_i = 1'b1;
                if (use_ce) begin bus.axi_ce_i = 1'b0; bus.axi_rready_i = 1'b1; end
                else        bus.axi_rready_i = 1'b0;
            end
            read_beat(base + 32'(4 * b), len);
        end
        repeat (drain_hold) @(posedge clk);
        @(posedge clk); #1;
        bus.axi_ren_i    = 1'b0;
        bus.axi_rready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] base, input int len, input logic [3:0] sel,
                            input bit rand_data, input logic [31:0] data0, input int gap_max,
                            input bit use_ce, input int bad_last);
        for (int b = 0; b <= len; b++) begin
            int          g;
            bit          got;
            logic [31:0] a;
            logic [31:0] d;
            a   = base + 32'(4 * b);
            d   = rand_data ? $urandom : data0 + 32'(b);
            got = 1'b0;
            g   = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(posedge clk); #1;
                bus.axi_wen_i = 1'b1;
                if (use_ce) begin bus.axi_ce_i = 1'b0; bus.axi_wvalid_i = 1'b1; end
                else        bus.axi_wvalid_i = 1'b0;
            end
            @(posedge clk); #1;
            bus.axi_ce_i     = 1'b1;
            bus.axi_wen_i    = 1'b1;
            bus.axi_wvalid_i = 1'b1;
            bus.axi_waddr_i  = a;
            bus.axi_wdata_i  = d;
            bus.axi_sel_i    = sel;
            bus.axi_wlen_i   = 4'(len);
            bus.axi_wlast_i  = (b == len) ^ (b == bad_last);
            model_write(a, d, sel);
            wr_q.push_back(cyc + WR_LAT);
            for (int i = 0; i < 64 && !got; i++) begin
                @(negedge clk);
                got = bus.wdata_resp_o;
            end
            check("wr_pulse_seen", 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        bus.axi_wen_i    = 1'b0;
        bus.axi_wvalid_i = 1'b0;
        bus.axi_wlast_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();
        @(negedge clk);
        check("reset_rdata_valid", 32'(bus.rdata_valid_o), 32'd0);
        check("reset_wdata_resp", 32'(bus.wdata_resp_o), 32'd0);
        check("reset_err", 32'(bus.err_o), 32'd0);
        check("reset_rdata", bus.rdata_o, 32'h0);

        // Single uncached read of a preloaded word.
        do_write(32'h40, 0, 4'hF, 1'b0, 32'hDEADBEEF, 0, 1'b0, -1);
        do_read(32'h40, 0, 0, 1'b0, 0);

        // 8-beat line read with back-to-back beats, then a few cycles held in drain.
        do_write(32'h100, 7, 4'hF, 1'b0, 32'h40, 0, 1'b0, -1);
        do_read(32'h100, 7, 0, 1'b0, 4);

        // 8-beat write with random data and read-back.
        do_write(32'h200, 7, 4'hF, 1'b1, 32'h0, 0, 1'b0, -1);
        do_read(32'h200, 7, 0, 1'b0, 0);
        check("err_after_clean_bursts", 32'(bus.err_o), 32'd0);

        // Byte-lane merge.
        do_write(32'h300, 0, 4'hF, 1'b0, 32'h11223344, 0, 1'b0, -1);
        do_write(32'h300, 0, 4'b0010, 1'b0, 32'h0000AB00, 0, 1'b0, -1);
        do_read(32'h300, 0, 0, 1'b0, 0);

        // Prefill a random-test region, then mixed random traffic with aliased addresses.
        for (int l = 0; l < 32; l++) begin
            do_write(32'h1000 + 32'(l * 32), 7, 4'hF, 1'b1, 32'h0, 1, 1'b0, -1);
        end
        for (int it = 0; it < 40; it++) begin
            int          op;
            int          off;
            logic [31:0] hi;
            logic [31:0] rb;
            logic [31:0] wb;
            op  = int'($urandom_range(3, 0));
            off = int'($urandom_range(7, 0));
            hi  = $urandom & 32'hFFFF_0000;
            rb  = hi + 32'h1000 + 32'($urandom_range(15, 0) * 32);
            wb  = hi + 32'h1200 + 32'($urandom_range(15, 0) * 32);
            if ($urandom_range(1, 0) != 0) begin
                logic [31:0] t;
                t  = rb - 32'h0 + 32'h200;
                wb = rb;
                rb = t;
            end
            case (op)
                0: do_write(wb, 7, 4'($urandom_range(15, 0)), 1'b1, 32'h0, 2,
                            $urandom_range(1, 0) != 0, -1);
                1: do_read(rb, 7, 2, $urandom_range(1, 0) != 0, int'($urandom_range(2, 0)));
                2: begin
                    if ($urandom_range(1, 0) != 0)
                        do_write(wb + 32'(4 * off), 0, 4'($urandom_range(15, 0)), 1'b1, 32'h0, 2, 1'b1, -1);
                    else
                        do_read(rb + 32'(4 * off), 0, 2, 1'b1, 0);
                end
                default: begin
                    fork
                        do_read(rb, 7, 2, 1'b0, 0);
                        do_write(wb, 7, 4'($urandom_range(15, 0)), 1'b1, 32'h0, 2, 1'b0, -1);
                    join
                end
            endcase
        end
        check("err_after_random", 32'(bus.err_o), 32'd0);

        // Reset in the middle of a read burst: no further pulse, memory retained.
        for (int b = 0; b < 4; b++) read_beat(32'h100 + 32'(4 * b), 7);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("rst_mid_read_valid", 32'(bus.rdata_valid_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_valid", 32'(bus.rdata_valid_o), 32'd0);
        check("after_rst_err", 32'(bus.err_o), 32'd0);
        do_read(32'h100, 0, 0, 1'b0, 0);
        do_read(32'h100, 7, 0, 1'b0, 0);

        // Reset on the commit cycle drops the uncommitted write beat.
        do_write(32'h400, 0, 4'hF, 1'b0, 32'hCAFEF00D, 0, 1'b0, -1);
        @(posedge clk); #1;
        bus.axi_wen_i    = 1'b1;
        bus.axi_wvalid_i = 1'b1;
        bus.axi_waddr_i  = 32'h400;
        bus.axi_wdata_i  = 32'h12345678;
        bus.axi_sel_i    = 4'hF;
        bus.axi_wlen_i   = 4'h0;
        bus.axi_wlast_i  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("dropped_write_no_resp", 32'(bus.wdata_resp_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_read(32'h400, 0, 0, 1'b0, 0);

        // Early wlast: error is flagged, stays set, and the beats still land.
        do_write(32'h500, 7, 4'hF, 1'b1, 32'h0, 0, 1'b0, 3);
        check("err_early_wlast", 32'(bus.err_o), 32'd1);
        do_read(32'h500, 7, 1, 1'b0, 0);
        check("err_sticky", 32'(bus.err_o), 32'd1);
        do_reset();
        @(negedge clk);
        check("err_cleared_by_rst", 32'(bus.err_o), 32'd0);

        // Misaligned read address: low bits treated as zero, error flagged.
        do_read(32'h102, 0, 0, 1'b0, 0);
        check("err_misaligned_read", 32'(bus.err_o), 32'd1);
        do_reset();

        // Truncated read burst: ren drops while the responder waits for the next beat.
        read_beat(32'h100, 7);
        read_beat(32'h104, 7);
        @(posedge clk); #1;
        bus.axi_ren_i    = 1'b0;
        bus.axi_rready_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("err_truncated_read", 32'(bus.err_o), 32'd1);
        do_reset();

        repeat (10) @(posedge clk);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_axi_responder.md
# cache_axi_responder

Memory-side responder for the simplified cache bus driven by the cache/AXI interface block. It accepts per-beat read and write requests (single-word uncached or 8-word cache-line bursts), serves them from an internal byte-writable word RAM with configurable latency, and returns `rdata_valid`/`wdata_resp` pulses beat by beat. It is the synthesizable memory model for SoC-less simulation and FPGA bring-up of the cache pipeline.

## Interface
- `ADDR_WIDTH`, 14: word-address bits. Memory depth is 2^ADDR_WIDTH words. Byte address bits above `ADDR_WIDTH+1` are ignored, so addresses alias.
- `RD_LATENCY`, 2: cycles from read-beat sample to `rdata_valid_o`. Legal range is 1..15.
- `WR_LATENCY`, 1: cycles from write-beat sample to `wdata_resp_o`. Legal range is 1..15.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `axi_ce_i` in 1: chip enable. When low, no new beat is sampled.
- `axi_sel_i` in 4: byte enables applied to writes.
- `axi_ren_i` in 1: read request, held for the whole burst.
- `axi_rready_i` in 1: initiator ready. Required high together with `axi_ren_i` to sample.
- `axi_raddr_i` in 32: byte address of the current read beat.
- `axi_rlen_i` in 4: beats minus one (0 or 7). Sampled on the first beat only.
- `rdata_o` out 32: read data. Valid only while `rdata_valid_o` is high.
- `rdata_valid_o` out 1: one-cycle pulse per read beat.
- `axi_wen_i` in 1: write request, held for the whole burst.
- `axi_wvalid_i` in 1: write data valid.
- `axi_waddr_i` in 32: byte address of the current write beat.
- `axi_wdata_i` in 32: write data of the current beat.
- `axi_wlast_i` in 1: marks the final write beat.
- `axi_wlen_i` in 4: beats minus one. Sampled on the first beat only.
- `wdata_resp_o` out 1: one-cycle pulse per committed write beat.
- `err_o` out 1: sticky protocol-error flag. Cleared only by `rst`.

## Operation
- The read and write channels are independent FSMs sharing one dual-port RAM.
- Read FSM states: R_IDLE, R_WAIT, R_RESP, R_NEXT, R_DRAIN.
  - R_IDLE: when `ren & rready & ce`, latch the word address, latch `rlen` and set beat=0, read the RAM, go to R_WAIT. If `RD_LATENCY==1`, go directly to R_RESP.
  - R_WAIT: count `RD_LATENCY-1` cycles, then go to R_RESP.
  - R_RESP: drive `rdata_valid_o=1` with the latched data. If beat==rlen, go to R_DRAIN; otherwise beat++ and go to R_NEXT.
  - R_NEXT: same sample rule as R_IDLE but keeps the latched rlen. If `ren` is low, go to R_IDLE and set `err_o` (burst truncated).
  - R_DRAIN: wait for `ren==0`, then go to R_IDLE.
- Write FSM states: W_IDLE, W_WAIT, W_RESP, W_NEXT, W_DRAIN. Same shape as the read FSM, with these differences:
  - Sample condition is `wen & wvalid & ce`.
  - Address, data and sel are latched at sample.
  - The RAM write commits in the W_RESP cycle, together with `wdata_resp_o=1`.
  - At sample, if `axi_wlast_i != (beat==wlen)`, set `err_o`. The beat is still written.
- If address bits [1:0] are nonzero at any sample, set `err_o`. The bits are treated as zero.
- Same word written in W_RESP and read-sampled in the same cycle: the read returns the old data.
- The RAM is never cleared by `rst`. It may be preloaded by `$readmemh` in simulation.

## Timing
- Reset values: `rdata_o=0`, `rdata_valid_o=0`, `wdata_resp_o=0`, `err_o=0`, both FSMs in IDLE. A reset mid-burst abandons the burst; an uncommitted write beat is dropped.
- Read beat: sample at cycle t, valid at t+RD_LATENCY, next sample no earlier than t+RD_LATENCY+1.
- 8-beat read with `RD_LATENCY=2`: valids at t+2, t+5, …, t+23.
- Write beat: sample at t, response and commit at t+WR_LATENCY.
- The one-cycle gap after each pulse lets the initiator advance its beat counter and address before the next sample.
- Read and write may be in flight simultaneously; neither channel stalls the other.
- `axi_ce_i` low suppresses sampling only. An in-flight beat still completes.

## Structure
- Shared package `cache_axi_resp_pkg` holds:
  - the read and write state encodings;
  - the beat-count width (4);
  - the latency-counter width (4).
- Sub-module `cache_axi_resp_ram`: simple dual-port RAM with one read port and one byte-enabled write port, 2^ADDR_WIDTH × 32, registered read.

## Test plan
- Single uncached read with `RD_LATENCY=2`: preload word 0x10 = 0xDEADBEEF, `raddr=0x40`, `rlen=0` → exactly one `rdata_valid_o` pulse, at t+2, with `rdata_o=0xDEADBEEF`.
- 8-beat line read at 0x100 with the initiator advancing the address per pulse → 8 pulses spaced 3 cycles apart, data words 0x40..0x47 in order, then R_DRAIN until `ren` drops.
- 8-beat write at 0x200 with `wlast` on beat 7, followed by a read-back → 8 `wdata_resp_o` pulses, memory matches, `err_o=0`.
- Byte write `sel=4'b0010`, `wdata=0x0000AB00` onto 0x11223344 → read-back returns 0x1122AB44.
- Protocol errors: `wlast` asserted on beat 3 of a `wlen=7` burst → `err_o=1` and it stays set. Separately, `raddr=0x102` → `err_o=1`.
- Concurrency and reset: a read burst and a write burst at the same time complete independently. `rst` at read beat 4 → `rdata_valid_o=0` next cycle, FSM in IDLE, memory contents retained.
